// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven run/pause/lap/done sequencer for the stopwatch counter chain (STOPWATCH_LAP_COUNT_EN adds LAP_CNT)
module stopwatch_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int LAP_MAX    = 9
) (
  input  logic                    CLK,
  input  logic                    SCLR,
  input  logic                    TICK,
  input  logic                    BTN_SS,
  input  logic                    BTN_LR,
  input  logic                    AT_LIMIT,
  input  logic [4*NUM_DIGITS-1:0] DIGITS_IN,
  output logic                    CE_OUT,
  output logic                    CLR_OUT,
  output logic [4*NUM_DIGITS-1:0] DIGITS_OUT,
  output logic [2:0]              STATE
`ifdef STOPWATCH_LAP_COUNT_EN
  ,
  output logic [3:0]              LAP_CNT
`endif
);
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, PAUSED = 3'd2, LAP = 3'd3, DONE = 3'd4} state_t;
  state_t state, state_d;
  logic [4*NUM_DIGITS-1:0] hold;
  logic ss_prev, lr_prev, clr_q, clr_d, cap, ss_ev, lr_ev, counting;
  assign ss_ev    = BTN_SS & ~ss_prev;
  assign lr_ev    = BTN_LR & ~lr_prev;
  assign counting = (state == RUN) | (state == LAP);
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      state   <= IDLE;
      hold    <= '0;
      ss_prev <= 1'b1;
      lr_prev <= 1'b1;
      clr_q   <= 1'b0;
    end else begin
      state   <= state_d;
      ss_prev <= BTN_SS;
      lr_prev <= BTN_LR;
      clr_q   <= clr_d;
      if (cap) hold <= DIGITS_IN;
    end
  end
  // the limit check outranks every button; ss outranks lr
  always_comb begin
    state_d = state;
    cap     = 1'b0;
    clr_d   = 1'b0;
    if (counting && AT_LIMIT) state_d = DONE;
    else if (ss_ev) state_d = (state == IDLE || state == PAUSED) ? RUN : counting ? PAUSED : state;
    else if (lr_ev) begin
      if (state == RUN) begin
        state_d = LAP;
        cap     = 1'b1;
      end else if (state == LAP) state_d = RUN;
      else begin
        state_d = IDLE;
        clr_d   = 1'b1;
      end
    end
  end
  assign CE_OUT     = TICK & counting & ~AT_LIMIT;
  assign CLR_OUT    = SCLR | clr_q;
  assign DIGITS_OUT = (state == LAP) ? hold : DIGITS_IN;
  assign STATE      = state;
`ifdef STOPWATCH_LAP_COUNT_EN
  always_ff @(posedge CLK) begin
    if (SCLR || clr_q) LAP_CNT <= 4'd0;
    else if (cap && LAP_CNT != 4'(LAP_MAX)) LAP_CNT <= LAP_CNT + 4'd1;
  end
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random checks of stopwatch_ctrl against a rule-level model
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic sclr, tick, ss, lr, lim;
  logic [15:0] din, dout;
  logic ce, clr;
  logic [2:0] st;
  int errors = 0, checks = 0, ce_seen = 0;
  int m_st, m_ssp, m_lrp, m_clr, m_lap;
  logic [15:0] m_hold;
`ifdef STOPWATCH_LAP_COUNT_EN
  logic [3:0] lap_cnt;
`endif

  stopwatch_ctrl #(.NUM_DIGITS(4), .LAP_MAX(9)) dut (
    .CLK(clk), .SCLR(sclr), .TICK(tick), .BTN_SS(ss), .BTN_LR(lr), .AT_LIMIT(lim),
    .DIGITS_IN(din), .CE_OUT(ce), .CLR_OUT(clr), .DIGITS_OUT(dout), .STATE(st)
`ifdef STOPWATCH_LAP_COUNT_EN
    , .LAP_CNT(lap_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: check outputs against the model, then advance the model by the rules
  task automatic cyc();
    bit ssev, lrev, running;
    int nst, nclr, nlap;
    #1;
    running = (m_st == 1 || m_st == 3);
    chk("state", 32'(st), 32'(m_st));
    chk("clr", 32'(clr), 32'(sclr | (m_clr != 0)));
    chk("ce", 32'(ce), 32'(tick & running & ~lim));
    chk("dout", 32'(dout), 32'(m_st == 3 ? m_hold : din));
`ifdef STOPWATCH_LAP_COUNT_EN
    chk("lap_cnt", 32'(lap_cnt), 32'(m_lap));
`endif
    if (ce) ce_seen++;
    if (sclr) begin
      m_st = 0; m_hold = 0; m_ssp = 1; m_lrp = 1; m_clr = 0; m_lap = 0;
    end else begin
      ssev = ss && !m_ssp;
      lrev = lr && !m_lrp;
      nst = m_st; nclr = 0; nlap = (m_clr != 0) ? 0 : m_lap;
      if (running && lim) nst = 4;
      else if (ssev) begin
        if (m_st == 0 || m_st == 2) nst = 1;
        else if (running) nst = 2;
      end else if (lrev) begin
        if (m_st == 1) begin
          nst = 3; m_hold = din;
          if (nlap < 9) nlap++;
        end else if (m_st == 3) nst = 1;
        else begin nst = 0; nclr = 1; end
      end
      m_st = nst; m_clr = nclr; m_lap = nlap; m_ssp = ss; m_lrp = lr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press_ss(); ss = 1; cyc(); ss = 0; cyc(); endtask
  task automatic press_lr(); lr = 1; cyc(); lr = 0; cyc(); endtask

  initial begin
    sclr = 1; tick = 0; ss = 1; lr = 0; lim = 0; din = 16'h0000;
    @(posedge clk); #1;
    m_st = 0; m_hold = 0; m_ssp = 1; m_lrp = 1; m_clr = 0; m_lap = 0;
    // reset with start/stop held: no event until released and pressed again
    cyc(); cyc();
    sclr = 0;
    cyc(); cyc();
    chk("held_no_run", 32'(st), 32'd0);
    chk("clr_after_rst", 32'(clr), 32'd0);
    ss = 0; cyc();
    press_ss();
    chk("run", 32'(st), 32'd1);
    // 25 ticks, the last coincident with the stop press
    ce_seen = 0;
    for (int i = 0; i < 24; i++) begin tick = 1; cyc(); tick = 0; cyc(); end
    tick = 1; ss = 1; cyc();
    tick = 0; ss = 0; cyc();
    chk("ce25", 32'(ce_seen), 32'd25);
    chk("paused", 32'(st), 32'd2);
    // lap freeze
    press_ss();
    din = 16'h0123; press_lr();
    for (int i = 0; i < 6; i++) begin din = 16'(16'h0200 + i * 17); tick = 1; cyc(); end
    tick = 0;
    chk("lap_state", 32'(st), 32'd3);
    chk("lap_hold", 32'(dout), 32'h0123);
    press_lr();
    din = 16'h0456; #1;
    chk("live_again", 32'(dout), 32'h0456);
`ifdef STOPWATCH_LAP_COUNT_EN
    chk("lap_one", 32'(lap_cnt), 32'd1);
`endif
    // limit beats a simultaneous stop press and tick
    lim = 1; tick = 1; ss = 1; cyc();
    tick = 0; ss = 0; cyc();
    chk("done", 32'(st), 32'd4);
    press_ss(); press_ss();
    chk("done_ignores_ss", 32'(st), 32'd4);
    lr = 1; cyc();
    chk("clr_pulse", 32'(clr), 32'd1);
    chk("idle_after_clr", 32'(st), 32'd0);
    lr = 0; lim = 0; cyc();
    chk("clr_one_clk", 32'(clr), 32'd0);
    // simultaneous ss and lr in RUN
    press_ss();
    din = 16'h0999; ss = 1; lr = 1; cyc();
    ss = 0; lr = 0; cyc();
    chk("ss_wins", 32'(st), 32'd2);
    chk("no_clr", 32'(clr), 32'd0);
    // twelve laps, then pause and clear
    press_ss();
    for (int i = 0; i < 12; i++) begin din = 16'(i); press_lr(); press_lr(); end
`ifdef STOPWATCH_LAP_COUNT_EN
    chk("lap_sat", 32'(lap_cnt), 32'd9);
`endif
    press_ss();
    press_lr();
    cyc();
`ifdef STOPWATCH_LAP_COUNT_EN
    chk("lap_cleared", 32'(lap_cnt), 32'd0);
`endif
    chk("idle_final", 32'(st), 32'd0);
    // random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) ss = ~ss;
      if ($urandom_range(0, 6) == 0) lr = ~lr;
      if ($urandom_range(0, 40) == 0) lim = ~lim;
      tick = ($urandom_range(0, 2) == 0);
      sclr = ($urandom_range(0, 150) == 0);
      din = 16'($urandom);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the stopwatch counter chain (tenths, seconds, tens-of-seconds and minutes mod counters).
- Turns two debounced pushbuttons into counter enable and clear commands, and freezes the displayed value for lap timing.
- Stops counting when the counter chain reports its limit.
- Runs on the fast system clock and advances the counters through a 10 Hz tick strobe. It sits between the button debouncers, the counter chain and the 7-segment display mux.

Parameters:
- NUM_DIGITS, 4: number of BCD digits passed through from counters to display.
- LAP_MAX, 9: saturation value of the optional lap counter.

Ports:
- CLK  in  1  system clock.
- SCLR  in  1  synchronous, active-high reset.
- TICK  in  1  one-CLK-wide 10 Hz strobe.
- BTN_SS  in  1  debounced start/stop button, level.
- BTN_LR  in  1  debounced lap/reset button, level.
- AT_LIMIT  in  1  counter chain at its terminal value (5:00.0).
- DIGITS_IN  in  4*NUM_DIGITS  live BCD count from counters; digit 0 (tenths) in the LSBs.
- CE_OUT  out  1  clock enable to the counter chain.
- CLR_OUT  out  1  synchronous clear to the counter chain.
- DIGITS_OUT  out  4*NUM_DIGITS  BCD value to the display.
- STATE  out  3  current FSM state code.
- LAP_CNT  out  4  laps taken; present only with the optional feature.

Behaviour:
- One clock; all registers update on rising CLK; SCLR is synchronous and active-high.
- Reset values:
  - state IDLE (STATE=0).
  - hold register 0.
  - button-history registers 1, so a button held through reset produces no event.
  - clear pulse register 0.
  - CE_OUT=0.
  - CLR_OUT=1 while SCLR is high.
- Button events: ss_ev = BTN_SS & ~ss_prev; lr_ev = BTN_LR & ~lr_prev. One event per press. The state change is visible the CLK after the rising edge is sampled.
- State codes: IDLE=0, RUN=1, PAUSED=2, LAP=3, DONE=4.
- Transitions, priority top-down:
  - RUN or LAP with AT_LIMIT=1 -> DONE. Button events that cycle are dropped.
  - ss_ev and lr_ev in the same cycle: ss_ev wins, lr_ev is discarded.
  - IDLE + ss_ev -> RUN.
  - RUN + ss_ev -> PAUSED.
  - LAP + ss_ev -> PAUSED; display releases to live.
  - PAUSED + ss_ev -> RUN.
  - DONE + ss_ev: ignored.
  - RUN + lr_ev -> LAP; hold register <= DIGITS_IN on that edge.
  - LAP + lr_ev -> RUN.
  - LAP + lr_ev with no ss_ev: a new lap cannot be taken directly from LAP; the press returns to live display.
  - PAUSED, DONE or IDLE + lr_ev -> IDLE; clear pulse register set for exactly one CLK.
- CE_OUT = TICK & (state==RUN | state==LAP) & ~AT_LIMIT, combinational from the current state.
  - A TICK in the same cycle as a stop press still counts.
  - A TICK in the same cycle as a start press from IDLE/PAUSED does not count.
- CLR_OUT = SCLR | clear pulse register. The pulse is high the CLK after the lr_ev cycle, for one CLK only. The counters are zero one CLK later. DIGITS_OUT follows DIGITS_IN live.
- DIGITS_OUT: hold register in LAP; DIGITS_IN in all other states. DONE shows the live value (5:00.0), since the counters are stopped.
- SCLR in any state returns to IDLE the next CLK. It overrides all events and clears the counter chain via CLR_OUT.
- AT_LIMIT high in IDLE/PAUSED has no effect on state. ss_ev from PAUSED with AT_LIMIT high goes to RUN, then DONE the next CLK; CE_OUT stays 0 throughout.

Optional Feature:
- Macro: STOPWATCH_LAP_COUNT_EN.
- Defined:
  - LAP_CNT port exists.
  - Increments on each RUN->LAP transition and saturates at LAP_MAX.
  - Resets to 0 on SCLR and whenever the clear pulse fires.
  - Holds its value in DONE and PAUSED.
- Undefined: LAP_CNT port and logic are absent; all other behaviour is identical.

Test Plan:
- SCLR 2 CLK with BTN_SS held high, then release SCLR -> STATE=0, CLR_OUT=1 only during SCLR, no transition to RUN until BTN_SS is released and pressed again.
- Press SS, apply 25 TICKs, press SS -> CE_OUT pulses exactly 25 times, STATE=2; a TICK coincident with the stop press is counted.
- In RUN with DIGITS_IN=0x0123, press LR; ramp DIGITS_IN -> DIGITS_OUT stays 0x0123 while STATE=3. Press LR again -> DIGITS_OUT tracks DIGITS_IN; with the macro defined, LAP_CNT=1.
- In RUN, raise AT_LIMIT with TICK high and SS pressed in the same cycle -> CE_OUT=0, STATE=4 next CLK. Later SS presses are ignored. Press LR -> CLR_OUT high for exactly 1 CLK, STATE=0.
- Press SS and LR together in RUN -> STATE=2, hold register unchanged, no clear pulse.
- Take 12 laps with the macro defined -> LAP_CNT saturates at 9. Pause, then press LR -> LAP_CNT=0 and CLR_OUT pulses once.
